// File: rtl/store_unit_pkg.sv
// Shared definitions for the store path: bus width, RAM base, store size and FSM encodings.
package store_unit_pkg;

  localparam int BUS_64 = 64;
  localparam logic [BUS_64-1:0] PC_START = 64'h8000_0000;
  localparam logic [BUS_64-1:0] RAM_BASE = PC_START;
  localparam logic [BUS_64-1:0] RAM_BYTES = 64'h0800_0000;

  typedef enum logic [1:0] {
    SZ_SB = 2'd0,
    SZ_SH = 2'd1,
    SZ_SW = 2'd2,
    SZ_SD = 2'd3
  } st_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR0  = 2'd1,
    ST_WR1  = 2'd2,
    ST_ERR  = 2'd3
  } st_state_e;

  // Each set byte-lane bit becomes eight set mask bits.
  function automatic logic [BUS_64-1:0] expand_bmask(input logic [7:0] bmask);
    logic [BUS_64-1:0] m;
    for (int i = 0; i < 8; i++) begin
      m[i*8 +: 8] = {8{bmask[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane alignment: turns (offset, size, data) into low/high word data and bit masks.
module store_lane_align
  import store_unit_pkg::*;
(
  input  logic [2:0]        off_i,
  input  logic [1:0]        size_i,
  input  logic [BUS_64-1:0] data_i,
  output logic              crosses_o,
  output logic [BUS_64-1:0] lo_wdata_o,
  output logic [BUS_64-1:0] lo_wmask_o,
  output logic [BUS_64-1:0] hi_wdata_o,
  output logic [BUS_64-1:0] hi_wmask_o
);

  logic [3:0]          nbytes;
  logic [15:0]         bmask16;
  logic [BUS_64-1:0]   data_trim;
  logic [2*BUS_64-1:0] data128;

  always_comb begin
    nbytes    = 4'd1;
    data_trim = '0;
    case (st_size_e'(size_i))
      SZ_SB: begin nbytes = 4'd1; data_trim = {56'b0, data_i[7:0]};  end
      SZ_SH: begin nbytes = 4'd2; data_trim = {48'b0, data_i[15:0]}; end
      SZ_SW: begin nbytes = 4'd4; data_trim = {32'b0, data_i[31:0]}; end
      SZ_SD: begin nbytes = 4'd8; data_trim = data_i;                end
      default: begin nbytes = 4'd1; data_trim = {56'b0, data_i[7:0]}; end
    endcase
    bmask16 = ((16'd1 << nbytes) - 16'd1) << off_i;
    data128 = {64'b0, data_trim} << {off_i, 3'b000};
  end

  assign crosses_o  = |bmask16[15:8];
  assign lo_wdata_o = data128[63:0];
  assign hi_wdata_o = data128[127:64];
  assign lo_wmask_o = expand_bmask(bmask16[7:0]);
  assign hi_wmask_o = expand_bmask(bmask16[15:8]);

endmodule

// File: rtl/store_unit.sv
// RV64 store unit driving the RAMHelper write port; one request at a time, registered outputs.
// Boundary-crossing stores are split into two writes when STORE_MISALIGN_SPLIT_EN is defined, else rejected.
module store_unit
  import store_unit_pkg::*;
#(
  parameter logic [BUS_64-1:0] BASE_ADDR = RAM_BASE,
  parameter logic [BUS_64-1:0] MEM_BYTES = RAM_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [BUS_64-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [BUS_64-1:0] req_data,
  output logic              done,
  output logic              err,
  output logic              ram_wen,
  output logic [BUS_64-1:0] ram_widx,
  output logic [BUS_64-1:0] ram_wdata,
  output logic [BUS_64-1:0] ram_wmask
);

  st_state_e         state_q, state_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              wen_q, wen_d;
  logic [BUS_64-1:0] widx_q, widx_d;
  logic [BUS_64-1:0] wdata_q, wdata_d;
  logic [BUS_64-1:0] wmask_q, wmask_d;

  logic              crosses;
  logic [BUS_64-1:0] lo_wdata, lo_wmask, hi_wdata, hi_wmask;
  logic [3:0]        nbytes;
  logic              range_err;
  logic [BUS_64-1:0] acc_idx;

  store_lane_align u_align (
    .off_i      (req_addr[2:0]),
    .size_i     (req_size),
    .data_i     (req_data),
    .crosses_o  (crosses),
    .lo_wdata_o (lo_wdata),
    .lo_wmask_o (lo_wmask),
    .hi_wdata_o (hi_wdata),
    .hi_wmask_o (hi_wmask)
  );

  // 65-bit compare so addresses near the top of the space cannot wrap into range.
  assign nbytes    = 4'd1 << req_size;
  assign range_err = (req_addr < BASE_ADDR) ||
                     (({1'b0, req_addr} + 65'(nbytes)) > ({1'b0, BASE_ADDR} + {1'b0, MEM_BYTES}));
  assign acc_idx   = (req_addr - BASE_ADDR) >> 3;

`ifdef STORE_MISALIGN_SPLIT_EN
  logic              split_q, split_d;
  logic [BUS_64-1:0] hi_wdata_q, hi_wdata_d;
  logic [BUS_64-1:0] hi_wmask_q, hi_wmask_d;
  logic              reject;
  assign reject = range_err;
`else
  logic reject;
  logic unused_hi;
  assign reject    = range_err || crosses;
  assign unused_hi = ^{hi_wdata, hi_wmask};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wen_q   <= 1'b0;
      widx_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
`ifdef STORE_MISALIGN_SPLIT_EN
      split_q    <= 1'b0;
      hi_wdata_q <= '0;
      hi_wmask_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wen_q   <= wen_d;
      widx_q  <= widx_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
`ifdef STORE_MISALIGN_SPLIT_EN
      split_q    <= split_d;
      hi_wdata_q <= hi_wdata_d;
      hi_wmask_q <= hi_wmask_d;
`endif
    end
  end

  // Outputs are registered, so each transition loads the values seen during the target state.
  always_comb begin
    state_d = state_q;
    ready_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wen_d   = 1'b0;
    widx_d  = widx_q;
    wdata_d = wdata_q;
    wmask_d = '0;
`ifdef STORE_MISALIGN_SPLIT_EN
    split_d    = split_q;
    hi_wdata_d = hi_wdata_q;
    hi_wmask_d = hi_wmask_q;
`endif
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (req_valid && ready_q) begin
          ready_d = 1'b0;
          if (reject) begin
            state_d = ST_ERR;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = ST_WR0;
            wen_d   = 1'b1;
            widx_d  = acc_idx;
            wdata_d = lo_wdata;
            wmask_d = lo_wmask;
            done_d  = !crosses;
`ifdef STORE_MISALIGN_SPLIT_EN
            split_d    = crosses;
            hi_wdata_d = hi_wdata;
            hi_wmask_d = hi_wmask;
`endif
          end
        end
      end
      ST_WR0: begin
`ifdef STORE_MISALIGN_SPLIT_EN
        if (split_q) begin
          state_d = ST_WR1;
          wen_d   = 1'b1;
          widx_d  = widx_q + 64'd1;
          wdata_d = hi_wdata_q;
          wmask_d = hi_wmask_q;
          done_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
`else
        state_d = ST_IDLE;
        ready_d = 1'b1;
`endif
      end
`ifdef STORE_MISALIGN_SPLIT_EN
      ST_WR1: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
`endif
      ST_ERR: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  assign req_ready = ready_q;
  assign done      = done_q;
  assign err       = err_q;
  assign ram_wen   = wen_q;
  assign ram_widx  = widx_q;
  assign ram_wdata = wdata_q;
  assign ram_wmask = wmask_q;

endmodule

// File: tb/tb_store_unit.sv
// Directed self-checking bench for store_unit; split expectations follow STORE_MISALIGN_SPLIT_EN.
module tb_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic [63:0] req_data = '0;
  logic        done, err, ram_wen;
  logic [63:0] ram_widx, ram_wdata, ram_wmask;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  store_unit dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_data  (req_data),
    .done      (done),
    .err       (err),
    .ram_wen   (ram_wen),
    .ram_widx  (ram_widx),
    .ram_wdata (ram_wdata),
    .ram_wmask (ram_wmask)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for req_ready, presents one request for exactly one edge, returns #1 after accept.
  task automatic issue(input logic [63:0] addr, input logic [1:0] size, input logic [63:0] data);
    int n = 0;
    while (req_ready !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready_timeout: req_ready=%b required 1", req_ready);
    end
    req_addr  = addr;
    req_size  = size;
    req_data  = data;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({req_ready, ram_wen, done, err} !== 4'b1000 || ram_wmask !== 64'h0 || ram_widx !== 64'h0 || ram_wdata !== 64'h0) begin
      errors++;
      $display("FAIL reset: ready/wen/done/err=%b%b%b%b widx=%h wdata=%h wmask=%h required 1000 and zeros",
               req_ready, ram_wen, done, err, ram_widx, ram_wdata, ram_wmask);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_sd_aligned();
    issue(64'h8000_0010, 2'd3, 64'h1122_3344_5566_7788);
    checks++;
    if ({ram_wen, done, err, req_ready} !== 4'b1100 || ram_widx !== 64'd2 ||
        ram_wdata !== 64'h1122_3344_5566_7788 || ram_wmask !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++;
      $display("FAIL sd_write: wen/done/err/ready=%b%b%b%b widx=%h wdata=%h wmask=%h required 1100 2 1122334455667788 all-ones",
               ram_wen, done, err, req_ready, ram_widx, ram_wdata, ram_wmask);
    end
    step();
    checks++;
    if ({req_ready, ram_wen, done} !== 3'b100 || ram_wmask !== 64'h0 ||
        ram_wdata !== 64'h1122_3344_5566_7788 || ram_widx !== 64'd2) begin
      errors++;
      $display("FAIL sd_after: ready/wen/done=%b%b%b wmask=%h wdata=%h widx=%h required 100 0 held held",
               req_ready, ram_wen, done, ram_wmask, ram_wdata, ram_widx);
    end
  endtask

  task automatic test_sb();
    issue(64'h8000_0005, 2'd0, 64'h0000_0000_0000_00AB);
    checks++;
    if ({ram_wen, done, err} !== 3'b110 || ram_widx !== 64'd0 ||
        ram_wdata !== 64'h0000_AB00_0000_0000 || ram_wmask !== 64'h0000_FF00_0000_0000) begin
      errors++;
      $display("FAIL sb_write: wen/done/err=%b%b%b widx=%h wdata=%h wmask=%h required 110 0 0000AB0000000000 0000FF0000000000",
               ram_wen, done, err, ram_widx, ram_wdata, ram_wmask);
    end
    step();
  endtask

  task automatic test_upper_ignored();
    issue(64'h8000_0022, 2'd1, 64'h9ABC_DEF0_1357_BEEF);
    checks++;
    if ({ram_wen, done} !== 2'b11 || ram_widx !== 64'd4 || ram_wmask !== 64'h0000_0000_FFFF_0000 ||
        (ram_wdata & ram_wmask) !== 64'h0000_0000_BEEF_0000) begin
      errors++;
      $display("FAIL sh_upper_ignored: wen/done=%b%b widx=%h wdata=%h wmask=%h required 11 4 BEEF0000 in lanes 0000FFFF0000",
               ram_wen, done, ram_widx, ram_wdata, ram_wmask);
    end
    step();
  endtask

  task automatic test_split();
    issue(64'h8000_0006, 2'd2, 64'h0000_0000_DEAD_BEEF);
`ifdef STORE_MISALIGN_SPLIT_EN
    checks++;
    if ({ram_wen, done, err} !== 3'b100 || ram_widx !== 64'd0 ||
        ram_wdata !== 64'hBEEF_0000_0000_0000 || ram_wmask !== 64'hFFFF_0000_0000_0000) begin
      errors++;
      $display("FAIL split_wr0: wen/done/err=%b%b%b widx=%h wdata=%h wmask=%h required 100 0 BEEF000000000000 FFFF000000000000",
               ram_wen, done, err, ram_widx, ram_wdata, ram_wmask);
    end
    step();
    checks++;
    if ({ram_wen, done, err, req_ready} !== 4'b1100 || ram_widx !== 64'd1 ||
        ram_wdata !== 64'h0000_0000_0000_DEAD || ram_wmask !== 64'h0000_0000_0000_FFFF) begin
      errors++;
      $display("FAIL split_wr1: wen/done/err/ready=%b%b%b%b widx=%h wdata=%h wmask=%h required 1100 1 DEAD FFFF",
               ram_wen, done, err, req_ready, ram_widx, ram_wdata, ram_wmask);
    end
`else
    checks++;
    if ({ram_wen, done, err} !== 3'b011 || ram_wmask !== 64'h0) begin
      errors++;
      $display("FAIL split_reject: wen/done/err=%b%b%b wmask=%h required 011 0", ram_wen, done, err, ram_wmask);
    end
`endif
    step();
    checks++;
    if ({req_ready, ram_wen, done, err} !== 4'b1000) begin
      errors++;
      $display("FAIL split_idle: ready/wen/done/err=%b%b%b%b required 1000", req_ready, ram_wen, done, err);
    end
  endtask

  task automatic test_range();
    logic [63:0] bad_addr [3];
    logic [1:0]  bad_size [3];
    bad_addr[0] = 64'h0000_0000_7FFF_FFFE; bad_size[0] = 2'd1;
    bad_addr[1] = 64'h0000_0000_87FF_FFFC; bad_size[1] = 2'd3;
    bad_addr[2] = 64'hFFFF_FFFF_FFFF_FFF8; bad_size[2] = 2'd3;
    for (int i = 0; i < 3; i++) begin
      issue(bad_addr[i], bad_size[i], 64'h0123_4567_89AB_CDEF);
      checks++;
      if ({ram_wen, done, err} !== 3'b011 || ram_wmask !== 64'h0) begin
        errors++;
        $display("FAIL range_err[%0d]: wen/done/err=%b%b%b wmask=%h required 011 0", i, ram_wen, done, err, ram_wmask);
      end
      step();
      checks++;
      if ({ram_wen, done, err} !== 3'b000) begin
        errors++;
        $display("FAIL range_after[%0d]: wen/done/err=%b%b%b required 000", i, ram_wen, done, err);
      end
    end
    // Last word of the window, ending exactly at the limit, is legal.
    issue(64'h8000_0000 + 64'h0800_0000 - 64'd4, 2'd2, 64'h0000_0000_CAFE_F00D);
    checks++;
    if ({ram_wen, done, err} !== 3'b110 || ram_widx !== 64'h00FF_FFFF ||
        ram_wdata !== 64'hCAFE_F00D_0000_0000 || ram_wmask !== 64'hFFFF_FFFF_0000_0000) begin
      errors++;
      $display("FAIL range_top_ok: wen/done/err=%b%b%b widx=%h wdata=%h wmask=%h required 110 FFFFFF CAFEF00D00000000 FFFFFFFF00000000",
               ram_wen, done, err, ram_widx, ram_wdata, ram_wmask);
    end
    step();
  endtask

  task automatic test_back_to_back();
    req_addr  = 64'h8000_0020;
    req_size  = 2'd1;
    req_data  = 64'h1234;
    req_valid = 1'b1;
    step();
    checks++;
    if ({ram_wen, done, req_ready} !== 3'b110 || ram_widx !== 64'd4 || ram_wdata !== 64'h1234 || ram_wmask !== 64'hFFFF) begin
      errors++;
      $display("FAIL b2b_first: wen/done/ready=%b%b%b widx=%h wdata=%h wmask=%h required 110 4 1234 FFFF",
               ram_wen, done, req_ready, ram_widx, ram_wdata, ram_wmask);
    end
    req_addr = 64'h8000_0008;
    req_size = 2'd0;
    req_data = 64'h5A;
    step();
    checks++;
    if ({ram_wen, done, req_ready} !== 3'b001) begin
      errors++;
      $display("FAIL b2b_gap: wen/done/ready=%b%b%b required 001", ram_wen, done, req_ready);
    end
    step();
    req_valid = 1'b0;
    checks++;
    if ({ram_wen, done} !== 2'b11 || ram_widx !== 64'd1 || ram_wdata !== 64'h5A || ram_wmask !== 64'hFF) begin
      errors++;
      $display("FAIL b2b_second: wen/done=%b%b widx=%h wdata=%h wmask=%h required 11 1 5A FF",
               ram_wen, done, ram_widx, ram_wdata, ram_wmask);
    end
    step();
  endtask

  task automatic test_reset_mid();
    issue(64'h8000_0006, 2'd2, 64'h0000_0000_DEAD_BEEF);
    rst = 1'b1;
    step();
    checks++;
    if ({req_ready, ram_wen, done, err} !== 4'b1000 || ram_wmask !== 64'h0 || ram_widx !== 64'h0) begin
      errors++;
      $display("FAIL reset_mid: ready/wen/done/err=%b%b%b%b wmask=%h widx=%h required 1000 0 0",
               req_ready, ram_wen, done, err, ram_wmask, ram_widx);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({req_ready, ram_wen, done, err} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_mid_after: ready/wen/done/err=%b%b%b%b required 1000", req_ready, ram_wen, done, err);
    end
  endtask

  initial begin
    test_reset();
    test_sd_aligned();
    test_sb();
    test_upper_ignored();
    test_split();
    test_range();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Write-side counterpart of the fetch path. The fetch stage only reads the shared RAMHelper port; this block drives its write side (wIdx/wdata/wmask/wen) for RV64 stores.
- Accepts one store request at a time and converts byte address, size and data into 64-bit-word-indexed, bit-masked RAM writes.
- Splits stores that cross an 8-byte boundary into two consecutive writes.
- Sits between the execute/memory stage and RAMHelper.

Parameters:
- BASE_ADDR, 64'h8000_0000: byte address mapped to RAM word index 0.
- MEM_BYTES, 64'h0800_0000: size of the RAM window in bytes; stores outside it are rejected.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  store request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_addr  in  64  byte address.
- req_size  in  2  store size: 0=SB, 1=SH, 2=SW, 3=SD.
- req_data  in  64  store data, right-aligned (LSB = first byte).
- done  out  1  one-cycle pulse when the request completes.
- err  out  1  valid with done; request rejected, nothing written.
- ram_wen  out  1  RAMHelper write enable.
- ram_widx  out  64  RAMHelper word index, (addr - BASE_ADDR) >> 3.
- ram_wdata  out  64  lane-aligned write data.
- ram_wmask  out  64  bit mask; each byte lane is all-ones or all-zeros.

Behaviour:
- All outputs are registered. Reset values: req_ready=1, done=0, err=0, ram_wen=0, ram_widx=0, ram_wdata=0, ram_wmask=0, state=IDLE.
- Accept: req_valid && req_ready at a rising edge. Address, size and data are captured.
- Computation at accept:
  - off = addr[2:0]; nbytes = 1 << size.
  - bmask16 = ((1<<nbytes)-1) << off (16 bits).
  - data128 = {64'b0, data} << (8*off).
  - Low half: bmask16[7:0] with data128[63:0]. High half: bmask16[15:8] with data128[127:64].
  - Each mask byte expands to 8 mask bits.
- Range check: err if addr < BASE_ADDR or addr + nbytes > BASE_ADDR + MEM_BYTES. Compute in 65 bits so the sum cannot wrap.
- States: IDLE, WR0, WR1, ERR.
- IDLE: req_ready=1. On accept, go to ERR if the range check fails, otherwise to WR0. Next cycle req_ready=0.
- WR0: ram_wen=1, widx=idx, low half. If bmask16[15:8]!=0, go to WR1 with done=0. Otherwise done=1 this cycle and return to IDLE.
- WR1: ram_wen=1, widx=idx+1, high half, done=1, then IDLE.
- ERR: ram_wen=0, done=1, err=1 for one cycle, then IDLE.
- Latency: an aligned store writes 1 cycle after accept; a split store writes at cycles 1 and 2; done coincides with the last write.
- Throughput:
  - Non-split stores: one request per 2 cycles, because req_ready rises in the cycle after done.
  - Split stores: one per 3 cycles.
- In all non-write cycles: ram_wen=0, ram_wmask=0, and ram_wdata/ram_widx hold their previous values.
- req_data bits above the store size are ignored.
- Reset mid-operation: at the edge with rst=1, all outputs return to reset values, any pending WR1 is dropped (half-written store is accepted), and no done is issued.
- req_valid deasserting while in IDLE has no effect; there are no request buffers.

Optional Feature:
- Macro: STORE_MISALIGN_SPLIT_EN.
- Defined: boundary-crossing stores are split into WR0/WR1 as described above.
- Undefined:
  - Any request with bmask16[15:8]!=0 goes to ERR (done=1, err=1, no write).
  - The WR1 state and the idx+1 logic are not compiled.

Decomposition:
- Shared defines file additions:
  - store size encodings SB/SH/SW/SD.
  - state encodings for IDLE/WR0/WR1/ERR.
  - BUS_64 and the BASE address constant, reusing the existing PC_START definition.
- Sub-module store_lane_align: purely combinational. Maps (off, size, data) to bmask16 and data128, then expands byte masks to bit masks. Keeps the FSM file small.

Test Plan:
- Reset with rst=1 for 2 cycles -> req_ready=1; ram_wen, done, err, ram_wmask all 0.
- SD addr=0x8000_0010 data=0x1122334455667788:
  - next cycle: wen=1, widx=2, wdata=0x1122334455667788, wmask=all-ones, done=1.
  - the following cycle: req_ready=1.
- SB addr=0x8000_0005 data=0xAB -> widx=0, wdata=0x0000AB0000000000, wmask=0x0000FF0000000000, done=1.
- SW addr=0x8000_0006 data=0xDEADBEEF, split enabled:
  - cycle 1: widx=0, wdata[63:48]=0xBEEF, wmask=0xFFFF000000000000.
  - cycle 2: widx=1, wdata[15:0]=0xDEAD, wmask=0x000000000000FFFF, done=1.
  - Same request with the macro undefined -> done=1, err=1, wen never asserted.
- SH addr=0x7FFF_FFFE, and SD addr=BASE+MEM_BYTES-4 -> each gives done=1, err=1, no write.
- Split SW as above with rst=1 asserted during the WR0 cycle -> no WR1 write, no done, req_ready=1 after reset.
